data_sram_resp: RTL and testbench

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

---
 rtl/data_sram_resp_pkg.sv | 21 ++
 rtl/data_sram_resp_if.sv | 13 +
 rtl/data_sram_resp_sram_bank.sv | 28 ++
 rtl/data_sram_resp.sv | 113 +++++++++++
 tb/tb_data_sram_resp.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/data_sram_resp_pkg.sv
// Shared constants for data_sram_resp: CONFREG word offsets and the byte-lane merge helper.
// The optional TIMER register is enabled by defining CONFREG_TIMER_EN at build time.
package data_sram_resp_pkg;

   localparam logic [13:0] CFG_LED_W     = 14'h0000;
   localparam logic [13:0] CFG_SWITCH_W  = 14'h0001;
   localparam logic [13:0] CFG_TIMER_W   = 14'h0002;
   localparam logic [13:0] CFG_SCRATCH_W = 14'h0003;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  lanes);
      logic [31:0] res;
      res = old_w;
      for (int i = 0; i < 4; i++) begin
         if (lanes[i]) res[8*i +: 8] = new_w[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/data_sram_resp_if.sv
// Data-SRAM style request/response bus: CPU side is master, memory side is slave.
interface data_sram_resp_if;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;

   modport master (output data_sram_en, output data_sram_wen, output data_sram_addr,
                   output data_sram_wdata, input data_sram_rdata);
   modport slave  (input data_sram_en, input data_sram_wen, input data_sram_addr,
                   input data_sram_wdata, output data_sram_rdata);
endinterface

// File: rtl/data_sram_resp_sram_bank.sv
// sram_bank: 2**ADDR_W x 32 word array, byte-lane writes, read-first, 1-cycle read latency.
// Contents and read register are unreset; the read register holds while en is low.
module sram_bank #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              en_i,
   input  logic [3:0]        wen_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o
);

   logic [31:0] mem_q [0:(2**ADDR_W)-1];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en_i) begin
         rdata_q <= mem_q[addr_i];
         for (int i = 0; i < 4; i++) begin
            if (wen_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_resp.sv
// Data-SRAM responder: RAM bank plus a 64 KiB CONFREG window (LED, SWITCH, TIMER, SCRATCH).
// Read data lands one cycle after the access and holds otherwise; TIMER exists only with CONFREG_TIMER_EN.
module data_sram_resp
   import data_sram_resp_pkg::*;
#(
   parameter int          ADDR_W       = 10,
   parameter logic [31:0] CONFREG_BASE = 32'hBFAF_0000
) (
   input  logic                   clk,
   input  logic                   reset,
   data_sram_resp_if.slave        bus,
   output logic [15:0]            led,
   input  logic [15:0]            switch
);

   logic        access, cfg_hit, cfg_acc, cfg_wr, ram_en;
   logic [13:0] cfg_word;
   logic [31:0] cfg_rd, ram_rdata;

   logic        sel_cfg_q, sel_cfg_d;
   logic [31:0] cfg_rdata_q, cfg_rdata_d;
   logic [15:0] led_q, led_d;
   logic [31:0] scratch_q, scratch_d;
   logic [15:0] sw_sync1_q, sw_sync2_q;
`ifdef CONFREG_TIMER_EN
   logic [31:0] timer_q, timer_d;
`endif

   wire unused_addr = &{1'b0, bus.data_sram_addr[1:0]};

   assign access   = bus.data_sram_en & ~reset;
   assign cfg_hit  = (bus.data_sram_addr[31:16] == CONFREG_BASE[31:16]);
   assign cfg_acc  = access & cfg_hit;
   assign cfg_wr   = cfg_acc & (|bus.data_sram_wen);
   assign ram_en   = access & ~cfg_hit;
   assign cfg_word = bus.data_sram_addr[15:2];

   sram_bank #(.ADDR_W(ADDR_W)) u_bank (
      .clk     (clk),
      .en_i    (ram_en),
      .wen_i   (bus.data_sram_wen),
      .addr_i  (bus.data_sram_addr[ADDR_W+1:2]),
      .wdata_i (bus.data_sram_wdata),
      .rdata_o (ram_rdata)
   );

   always_comb begin
      cfg_rd = 32'h0;
      case (cfg_word)
         CFG_LED_W:     cfg_rd = {16'h0, led_q};
         CFG_SWITCH_W:  cfg_rd = {16'h0, sw_sync2_q};
`ifdef CONFREG_TIMER_EN
         CFG_TIMER_W:   cfg_rd = timer_q;
`endif
         CFG_SCRATCH_W: cfg_rd = scratch_q;
         default:       cfg_rd = 32'h0;
      endcase
   end

   always_comb begin
      sel_cfg_d   = sel_cfg_q;
      cfg_rdata_d = cfg_rdata_q;
      led_d       = led_q;
      scratch_d   = scratch_q;
      if (cfg_acc) begin
         sel_cfg_d   = 1'b1;
         cfg_rdata_d = cfg_rd;
      end else if (ram_en) begin
         sel_cfg_d   = 1'b0;
      end
      if (cfg_wr && cfg_word == CFG_LED_W) begin
         if (bus.data_sram_wen[0]) led_d[7:0]  = bus.data_sram_wdata[7:0];
         if (bus.data_sram_wen[1]) led_d[15:8] = bus.data_sram_wdata[15:8];
      end
      if (cfg_wr && cfg_word == CFG_SCRATCH_W)
         scratch_d = byte_merge(scratch_q, bus.data_sram_wdata, bus.data_sram_wen);
`ifdef CONFREG_TIMER_EN
      // A software write wins over the free-running increment for that cycle.
      timer_d = timer_q + 32'd1;
      if (cfg_wr && cfg_word == CFG_TIMER_W)
         timer_d = byte_merge(timer_q, bus.data_sram_wdata, bus.data_sram_wen);
`endif
   end

   // Selecting CONFREG with a zero capture on reset gives rdata = 0 without resetting the RAM path.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_cfg_q   <= 1'b1;
         cfg_rdata_q <= 32'h0;
         led_q       <= 16'h0;
         scratch_q   <= 32'h0;
         sw_sync1_q  <= 16'h0;
         sw_sync2_q  <= 16'h0;
`ifdef CONFREG_TIMER_EN
         timer_q     <= 32'h0;
`endif
      end else begin
         sel_cfg_q   <= sel_cfg_d;
         cfg_rdata_q <= cfg_rdata_d;
         led_q       <= led_d;
         scratch_q   <= scratch_d;
         sw_sync1_q  <= switch;
         sw_sync2_q  <= sw_sync1_q;
`ifdef CONFREG_TIMER_EN
         timer_q     <= timer_d;
`endif
      end
   end

   assign bus.data_sram_rdata = sel_cfg_q ? cfg_rdata_q : ram_rdata;
   assign led                 = led_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Scoreboard bench for data_sram_resp: a reference model predicts each access's read data,
// which is queued on drive and popped after the response edge.
module tb_data_sram_resp;
   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] led;
   logic [15:0] switch;

   data_sram_resp_if bus();

   data_sram_resp dut (
      .clk    (clk),
      .reset  (reset),
      .bus    (bus),
      .led    (led),
      .switch (switch)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] exp_q[$];
   logic [31:0] ram_m [int];
   logic [31:0] rdata_m, scratch_m, timer_m;
   logic [15:0] led_m, sync1_m, sync2_m;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] w);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = n[8*i +: 8];
      return r;
   endfunction

   // One clock cycle: drive, predict, advance, compare.
   task automatic cyc(input logic rst, input logic en, input logic [3:0] wen,
                      input logic [31:0] addr, input logic [31:0] wdata);
      logic        hit;
      logic [13:0] w;
      logic [31:0] old;
      int          idx;
      reset               = rst;
      bus.data_sram_en    = en;
      bus.data_sram_wen   = wen;
      bus.data_sram_addr  = addr;
      bus.data_sram_wdata = wdata;
      hit = (addr[31:16] == 16'hBFAF);
      w   = addr[15:2];
      idx = int'(addr[11:2]);
      old = 32'h0;
      if (en && !rst) begin
         if (hit) begin
            case (w)
               14'd0: old = {16'h0, led_m};
               14'd1: old = {16'h0, sync2_m};
`ifdef CONFREG_TIMER_EN
               14'd2: old = timer_m;
`endif
               14'd3: old = scratch_m;
               default: old = 32'h0;
            endcase
         end else begin
            old = ram_m.exists(idx) ? ram_m[idx] : 32'hxxxx_xxxx;
         end
         exp_q.push_back(old);
      end
      if (rst) begin
         led_m = 16'h0; scratch_m = 32'h0; timer_m = 32'h0;
         sync1_m = 16'h0; sync2_m = 16'h0;
      end else begin
         timer_m = timer_m + 32'd1;
         sync2_m = sync1_m;
         sync1_m = switch;
         if (en && wen != 4'h0) begin
            if (!hit) ram_m[idx] = merge(ram_m.exists(idx) ? ram_m[idx] : 32'h0, wdata, wen);
            else if (w == 14'd0) led_m = merge({16'h0, led_m}, wdata, wen & 4'b0011);
            else if (w == 14'd2) timer_m = merge(timer_m - 32'd1, wdata, wen);
            else if (w == 14'd3) scratch_m = merge(scratch_m, wdata, wen);
         end
      end
      @(posedge clk);
      #1;
      if (rst) rdata_m = 32'h0;
      else if (en) rdata_m = exp_q.pop_front();
      chk("rdata", bus.data_sram_rdata, rdata_m);
      chk("led", {16'h0, led}, {16'h0, led_m});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   initial begin
      logic [31:0] a, d;
      logic [3:0]  wn;
      switch = 16'h0;
      led_m = 16'h0; scratch_m = 32'h0; timer_m = 32'h0;
      sync1_m = 16'h0; sync2_m = 16'h0; rdata_m = 32'h0;
      cyc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
      cyc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);

      // RAM full write then read
      cyc(1'b0, 1'b1, 4'hF, 32'h0000_0010, 32'h1234_5678);
      cyc(1'b0, 1'b1, 4'h0, 32'h0000_0010, 32'h0);
      chk("ram_full_read", bus.data_sram_rdata, 32'h1234_5678);
      // Partial-lane write returns pre-write data
      cyc(1'b0, 1'b1, 4'b0101, 32'h0000_0010, 32'hAABB_CCDD);
      chk("ram_read_first", bus.data_sram_rdata, 32'h1234_5678);
      cyc(1'b0, 1'b1, 4'h0, 32'h0000_0010, 32'h0);
      chk("ram_lane_merge", bus.data_sram_rdata, 32'h12BB_56DD);
      idle(2);
      chk("rdata_hold", bus.data_sram_rdata, 32'h12BB_56DD);
      // Upper address bits alias onto the same word
      cyc(1'b0, 1'b1, 4'hF, 32'h1000_1010, 32'hCAFE_F00D);
      cyc(1'b0, 1'b1, 4'h0, 32'h0000_0010, 32'h0);
      chk("ram_alias", bus.data_sram_rdata, 32'hCAFE_F00D);

      // LED
      cyc(1'b0, 1'b1, 4'hF, 32'hBFAF_0000, 32'h0000_A5A5);
      chk("led_write", {16'h0, led}, 32'h0000_A5A5);
      cyc(1'b0, 1'b1, 4'h0, 32'hBFAF_0000, 32'h0);
      chk("led_read", bus.data_sram_rdata, 32'h0000_A5A5);
      cyc(1'b0, 1'b1, 4'b1100, 32'hBFAF_0000, 32'hFFFF_FFFF);
      chk("led_upper_ignored", {16'h0, led}, 32'h0000_A5A5);

      // SWITCH synchroniser and read-only
      switch = 16'h00F0;
      idle(2);
      cyc(1'b0, 1'b1, 4'h0, 32'hBFAF_0004, 32'h0);
      chk("switch_read", bus.data_sram_rdata, 32'h0000_00F0);
      cyc(1'b0, 1'b1, 4'hF, 32'hBFAF_0004, 32'h1111_1111);
      cyc(1'b0, 1'b1, 4'h0, 32'hBFAF_0004, 32'h0);
      chk("switch_ro", bus.data_sram_rdata, 32'h0000_00F0);

      // SCRATCH and unmapped offsets
      cyc(1'b0, 1'b1, 4'hF, 32'hBFAF_000C, 32'h0BAD_F00D);
      cyc(1'b0, 1'b1, 4'b1000, 32'hBFAF_000C, 32'h7700_0000);
      cyc(1'b0, 1'b1, 4'h0, 32'hBFAF_000C, 32'h0);
      chk("scratch", bus.data_sram_rdata, 32'h77AD_F00D);
      cyc(1'b0, 1'b1, 4'hF, 32'hBFAF_0010, 32'hFFFF_FFFF);
      cyc(1'b0, 1'b1, 4'h0, 32'hBFAF_0010, 32'h0);
      chk("unmapped", bus.data_sram_rdata, 32'h0);

      // TIMER wrap
      cyc(1'b0, 1'b1, 4'hF, 32'hBFAF_0008, 32'hFFFF_FFFE);
      idle(2);
      cyc(1'b0, 1'b1, 4'h0, 32'hBFAF_0008, 32'h0);
      chk("timer_wrap", bus.data_sram_rdata, 32'h0);
      idle(3);
      cyc(1'b0, 1'b1, 4'h0, 32'hBFAF_0008, 32'h0);
`ifdef CONFREG_TIMER_EN
      chk("timer_count", bus.data_sram_rdata, 32'h4);
`else
      chk("timer_absent", bus.data_sram_rdata, 32'h0);
`endif

      // Reset drops a coincident write
      cyc(1'b1, 1'b1, 4'hF, 32'hBFAF_0000, 32'hDEAD_BEEF);
      chk("reset_led", {16'h0, led}, 32'h0);
      chk("reset_rdata", bus.data_sram_rdata, 32'h0);
      cyc(1'b0, 1'b1, 4'h0, 32'hBFAF_0000, 32'h0);
      chk("led_after_reset", bus.data_sram_rdata, 32'h0);

      // Random mix over initialised RAM words and the CONFREG window
      for (int i = 0; i < 8; i++)
         cyc(1'b0, 1'b1, 4'hF, 32'h0000_0100 + 32'(4 * i), $urandom);
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 7) == 0) switch = 16'($urandom);
         if ($urandom_range(0, 1) == 0)
            a = 32'h0000_0100 + 32'(4 * $urandom_range(0, 7));
         else
            a = 32'hBFAF_0000 + 32'(4 * $urandom_range(0, 5));
         wn = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         d  = $urandom;
         cyc(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0), wn, a, d);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
